// File: rtl/bp_be_pkg.sv
// Shared types for the back-end prefetch sequencer slice.
package bp_be_pkg;

  // Sequencer FSM: wait for a descriptor, test one candidate line, offer one request
  typedef enum logic [1:0] {
    e_pref_idle,
    e_pref_gen,
    e_pref_emit
  } bp_be_pref_seq_state_e;

endpackage

// File: rtl/bp_be_prefetch_line_filter.sv
// Small fully associative filter of recently requested cache-line tags.
// Round-robin replacement; a clear wipes every entry and rewinds the pointer.
module bp_be_prefetch_line_filter
  import bp_be_pkg::*;
#(
  parameter int tag_width_p = 33,
  parameter int els_p       = 4
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   clear_i,
  input  logic [tag_width_p-1:0] lookup_tag_i,
  output logic                   hit_o,
  input  logic                   insert_v_i,
  input  logic [tag_width_p-1:0] insert_tag_i
);

  localparam int ptr_width_lp = (els_p > 1) ? $clog2(els_p) : 1;

  logic [els_p-1:0][tag_width_p-1:0] tag_q, tag_d;
  logic [els_p-1:0]                  valid_q, valid_d;
  logic [ptr_width_lp-1:0]           ptr_q, ptr_d;

  // Associative match of the lookup tag against every valid entry
  always_comb begin
    hit_o = 1'b0;
    for (int i = 0; i < els_p; i++) begin
      if (valid_q[i] && (tag_q[i] == lookup_tag_i)) hit_o = 1'b1;
    end
  end

  // Next-state: clear has priority over an insert in the same cycle
  always_comb begin
    tag_d   = tag_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
    if (clear_i) begin
      valid_d = '0;
      ptr_d   = '0;
    end else if (insert_v_i) begin
      tag_d[ptr_q]   = insert_tag_i;
      valid_d[ptr_q] = 1'b1;
      ptr_d          = ptr_q + 1'b1;
    end
  end

  // Filter storage registers
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      tag_q   <= '0;
      valid_q <= '0;
      ptr_q   <= '0;
    end else begin
      tag_q   <= tag_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
    end
  end

endmodule

// File: rtl/bp_be_prefetch_sequencer.sv
// Expands a strided-loop descriptor into a stream of line-aligned prefetch
// requests, dropping lines already seen by the recent-line filter.
module bp_be_prefetch_sequencer
  import bp_be_pkg::*;
#(
  parameter int vaddr_width_p        = 39,
  parameter int stride_width_p       = 8,
  parameter int loop_range_p         = 8,
  parameter int block_offset_width_p = 6,
  parameter int filter_els_p         = 4
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      desc_v_i,
  output logic                      desc_ready_and_o,
  input  logic [vaddr_width_p-1:0]  desc_pc_i,
  input  logic [vaddr_width_p-1:0]  desc_eff_addr_i,
  input  logic [stride_width_p-1:0] desc_stride_i,
  input  logic [loop_range_p-1:0]   desc_count_i,
  input  logic                      flush_i,
  output logic                      v_o,
  output logic [vaddr_width_p-1:0]  addr_o,
  output logic [vaddr_width_p-1:0]  pc_o,
  input  logic                      yumi_i,
  output logic                      busy_o
);

  localparam int tag_width_lp = vaddr_width_p - block_offset_width_p;

  bp_be_pref_seq_state_e state_q, state_d;
  logic [vaddr_width_p-1:0] cur_q, cur_d;
  logic [vaddr_width_p-1:0] stride_q, stride_d;
  logic [vaddr_width_p-1:0] pc_q, pc_d;
  logic [vaddr_width_p-1:0] addr_q, addr_d;
  logic [vaddr_width_p-1:0] pc_out_q, pc_out_d;
  logic [loop_range_p-1:0]  rem_q, rem_d;

  logic [vaddr_width_p-1:0] desc_stride_sext;
  logic [tag_width_lp-1:0]  cur_tag;
  logic                     filter_hit;
  logic                     desc_accept;
  logic                     emit_taken;
  logic                     rem_last;

  assign desc_stride_sext = {{(vaddr_width_p-stride_width_p){desc_stride_i[stride_width_p-1]}},
                             desc_stride_i};
  assign cur_tag          = cur_q[vaddr_width_p-1:block_offset_width_p];
  assign desc_ready_and_o = (state_q == e_pref_idle) & ~flush_i & ~reset_i;
  assign desc_accept      = desc_v_i & desc_ready_and_o;
  assign v_o              = (state_q == e_pref_emit) & ~flush_i;
  assign emit_taken       = v_o & yumi_i;
  assign rem_last         = (rem_q == loop_range_p'(1));
  assign busy_o           = (state_q != e_pref_idle);
  assign addr_o           = addr_q;
  assign pc_o             = pc_out_q;

  bp_be_prefetch_line_filter #(
    .tag_width_p (tag_width_lp),
    .els_p       (filter_els_p)
  ) line_filter (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .clear_i      (flush_i),
    .lookup_tag_i (cur_tag),
    .hit_o        (filter_hit),
    .insert_v_i   (emit_taken),
    .insert_tag_i (addr_q[vaddr_width_p-1:block_offset_width_p])
  );

  // Sequencer next-state: accept, walk candidates, hold the offered request until taken
  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    stride_d = stride_q;
    pc_d     = pc_q;
    addr_d   = addr_q;
    pc_out_d = pc_out_q;
    rem_d    = rem_q;
    if (flush_i) begin
      state_d = e_pref_idle;
    end else begin
      case (state_q)
        e_pref_idle: begin
          if (desc_accept) begin
            cur_d    = desc_eff_addr_i + desc_stride_sext;
            stride_d = desc_stride_sext;
            pc_d     = desc_pc_i;
            if (desc_stride_i == '0)
              rem_d = (desc_count_i != '0) ? loop_range_p'(1) : '0;
            else
              rem_d = desc_count_i;
            state_d = (desc_count_i != '0) ? e_pref_gen : e_pref_idle;
          end
        end
        e_pref_gen: begin
          if (filter_hit) begin
            cur_d   = cur_q + stride_q;
            rem_d   = rem_q - 1'b1;
            state_d = rem_last ? e_pref_idle : e_pref_gen;
          end else begin
            addr_d   = {cur_tag, {block_offset_width_p{1'b0}}};
            pc_out_d = pc_q;
            state_d  = e_pref_emit;
          end
        end
        e_pref_emit: begin
          if (yumi_i) begin
            cur_d   = cur_q + stride_q;
            rem_d   = rem_q - 1'b1;
            state_d = rem_last ? e_pref_idle : e_pref_gen;
          end
        end
        default: state_d = e_pref_idle;
      endcase
    end
  end

  // Sequencer state and output registers
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= e_pref_idle;
      cur_q    <= '0;
      stride_q <= '0;
      pc_q     <= '0;
      addr_q   <= '0;
      pc_out_q <= '0;
      rem_q    <= '0;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      stride_q <= stride_d;
      pc_q     <= pc_d;
      addr_q   <= addr_d;
      pc_out_q <= pc_out_d;
      rem_q    <= rem_d;
    end
  end

endmodule
